// File: rtl/drive_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | drive_pkg : state codes and helpers shared by the manual-driving controller
// | Rev 1.0
// +---------------------------------------------------------------------------
package drive_pkg;

  localparam int c_state_w = 3;

  typedef enum logic [c_state_w-1:0] {
    ST_OFF       = 3'd0,
    ST_ON        = 3'd1,
    ST_NOT_START = 3'd2,
    ST_START     = 3'd3,
    ST_MOVING    = 3'd4
  } state_t;

  // States in which the gearbox is engaged and the reverse lamp follows the switch.
  function automatic logic is_drive_state(input state_t s);
    return (s == ST_START) || (s == ST_MOVING);
  endfunction

endpackage
`default_nettype wire

// File: rtl/turn_flasher.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | turn_flasher : half-period phase generator for one turn indicator
// | Rev 1.0
// +---------------------------------------------------------------------------
module turn_flasher #(
  parameter int FLASH_CYC = 50_000_000
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic en,
  output logic led
);

  localparam int c_cnt_w = $clog2(FLASH_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FLASH_CYC - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_phase_off;

  // Idle holds the "on" phase so a newly seen signal lights immediately.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_phase_off <= 1'b0;
    end else if (!en) begin
      r_cnt       <= '0;
      r_phase_off <= 1'b0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt       <= '0;
      r_phase_off <= ~r_phase_off;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign led = ~r_phase_off;

endmodule
`default_nettype wire

// File: rtl/drive_ctrl_fsm.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | drive_ctrl_fsm : power-up / ignition / motion sequencer with indicators
// | and a moving-time odometer. Rev 1.0
// +---------------------------------------------------------------------------
module drive_ctrl_fsm
  import drive_pkg::*;
#(
  parameter int HOLD_CYC     = 100_000_000,
  parameter int FLASH_CYC    = 50_000_000,
  parameter int ODO_TICK_CYC = 100_000_000,
  parameter int ODO_W        = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 power_on_signal,
  input  logic                 power_off_signal,
  input  logic                 manual_driving_signal,
  input  logic                 throttle_signal,
  input  logic                 clutch_signal,
  input  logic                 brake_signal,
  input  logic                 reverse_signal,
  input  logic                 turn_left_signal,
  input  logic                 turn_right_signal,
  output logic [c_state_w-1:0] state_o,
  output logic                 move_forward,
  output logic                 move_backward,
  output logic                 turn_left,
  output logic                 turn_right,
  output logic                 left_turn_led,
  output logic                 right_turn_led,
  output logic                 reverse_led,
  output logic [ODO_W-1:0]     odometer,
  output logic                 reverse_fault
);

  localparam int c_hold_w = $clog2(HOLD_CYC + 1);
  localparam int c_tick_w = $clog2(ODO_TICK_CYC + 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYC - 1);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(ODO_TICK_CYC - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_rev_q;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [c_tick_w-1:0] r_tick_cnt;
  logic [ODO_W-1:0]    r_odo;
  logic                r_fwd, r_bwd, r_tl, r_tr;
  logic                r_left_led, r_right_led, r_rev_led, r_fault;

  logic w_rev_chg, w_hold_done, w_fault, w_next_mov;
  logic w_flash_en_l, w_flash_en_r, w_phase_l, w_phase_r;

  // power_off outranks every other condition, including a reverse change in MOVING.
  always_comb begin
    w_rev_chg   = reverse_signal ^ r_rev_q;
    w_hold_done = power_on_signal & (r_hold_cnt == c_hold_last);
    w_next      = r_state;
    w_fault     = 1'b0;
    if (r_state != ST_OFF && power_off_signal) begin
      w_next = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (w_hold_done) w_next = ST_ON;
        end
        ST_ON: begin
          if (manual_driving_signal) w_next = ST_NOT_START;
        end
        ST_NOT_START: begin
          if (throttle_signal && !brake_signal) begin
            if (clutch_signal) w_next = ST_START;
            else               w_next = ST_OFF;
          end
        end
        ST_START: begin
          if (brake_signal)                          w_next = ST_NOT_START;
          else if (throttle_signal && !clutch_signal) w_next = ST_MOVING;
        end
        ST_MOVING: begin
          if (w_rev_chg && !clutch_signal) begin
            w_next  = ST_OFF;
            w_fault = 1'b1;
          end else if (brake_signal) begin
            w_next = ST_NOT_START;
          end else if (clutch_signal || !throttle_signal) begin
            w_next = ST_START;
          end
        end
        default: w_next = ST_OFF;
      endcase
    end
  end

  assign w_next_mov   = (w_next == ST_MOVING);
  assign w_flash_en_l = w_next_mov & turn_left_signal;
  assign w_flash_en_r = w_next_mov & turn_right_signal;

  turn_flasher #(.FLASH_CYC(FLASH_CYC)) u_flash_left (
    .sys_clk (sys_clk),
    .rst     (rst),
    .en      (w_flash_en_l),
    .led     (w_phase_l)
  );

  turn_flasher #(.FLASH_CYC(FLASH_CYC)) u_flash_right (
    .sys_clk (sys_clk),
    .rst     (rst),
    .en      (w_flash_en_r),
    .led     (w_phase_r)
  );

  // Outputs are taken from the next state so they move on the same edge as state_o.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_OFF;
      r_rev_q     <= 1'b0;
      r_fwd       <= 1'b0;
      r_bwd       <= 1'b0;
      r_tl        <= 1'b0;
      r_tr        <= 1'b0;
      r_left_led  <= 1'b0;
      r_right_led <= 1'b0;
      r_rev_led   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rev_q     <= reverse_signal;
      r_fwd       <= w_next_mov & ~reverse_signal;
      r_bwd       <= w_next_mov & reverse_signal;
      r_tl        <= w_next_mov & turn_left_signal;
      r_tr        <= w_next_mov & turn_right_signal;
      r_left_led  <= (w_next == ST_NOT_START) | (w_flash_en_l & w_phase_l);
      r_right_led <= (w_next == ST_NOT_START) | (w_flash_en_r & w_phase_r);
      r_rev_led   <= reverse_signal & is_drive_state(w_next);
      r_fault     <= w_fault;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
      r_tick_cnt <= '0;
      r_odo      <= '0;
    end else begin
      if (r_state == ST_OFF && power_on_signal && !w_hold_done) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end else begin
        r_hold_cnt <= '0;
      end

      if (w_next == ST_OFF) begin
        r_tick_cnt <= '0;
        r_odo      <= '0;
      end else if (w_next_mov) begin
        if (r_tick_cnt == c_tick_last) begin
          r_tick_cnt <= '0;
          r_odo      <= r_odo + 1'b1;
        end else begin
          r_tick_cnt <= r_tick_cnt + 1'b1;
        end
      end
    end
  end

  assign state_o        = r_state;
  assign move_forward   = r_fwd;
  assign move_backward  = r_bwd;
  assign turn_left      = r_tl;
  assign turn_right     = r_tr;
  assign left_turn_led  = r_left_led;
  assign right_turn_led = r_right_led;
  assign reverse_led    = r_rev_led;
  assign odometer       = r_odo;
  assign reverse_fault  = r_fault;

endmodule
`default_nettype wire

// File: doc/drive_ctrl_fsm.md
# drive_ctrl_fsm

Parametrised manual-driving controller for the simulated car. It sequences power-up, ignition and motion from the driver switches, and drives the motion bits in the UART frame to the car model. It also drives the turn and reverse indicator LEDs, with real turn-signal flashing, and counts a moving-time odometer for the seven-segment display. It sits between the debounced switch inputs and the UART/segment blocks in the device top.

## Interface

**Parameters**
- `HOLD_CYC`, default 100_000_000: cycles power_on_signal must be held to power up (1 s at 100 MHz).
- `FLASH_CYC`, default 50_000_000: half-period of turn-LED flashing, in cycles.
- `ODO_TICK_CYC`, default 100_000_000: cycles in MOVING per odometer increment.
- `ODO_W`, default 16: odometer width.

**Ports**
- `sys_clk` in 1: system clock. One clock domain.
- `rst` in 1: reset. Asynchronous and active-high.
- `power_on_signal`, `power_off_signal`, `manual_driving_signal` in 1 each: level inputs, already synchronous and debounced.
- `throttle_signal`, `clutch_signal`, `brake_signal`, `reverse_signal` in 1 each: level inputs.
- `turn_left_signal`, `turn_right_signal` in 1 each: level inputs.
- `state_o` out 3: current state code.
- `move_forward`, `move_backward`, `turn_left`, `turn_right` out 1 each: motion bits for the UART frame.
- `left_turn_led`, `right_turn_led`, `reverse_led` out 1 each: indicator LEDs.
- `odometer` out ODO_W: count of moving ticks.
- `reverse_fault` out 1: one-cycle pulse when reverse is changed without the clutch.

## Operation

**States**
- OFF = 0, ON = 1, NOT_START = 2, START = 3, MOVING = 4.
- Codes 5–7 are illegal and go to OFF on the next clock.

**Power-up**
- `hold_cnt` increments while in OFF and power_on_signal = 1. It clears when the signal is 0 or the state is not OFF.
- OFF→ON on the edge where power_on_signal = 1 and hold_cnt = HOLD_CYC-1.

**Transitions.** Priorities are listed highest first. power_off_signal = 1 forces any non-OFF state to OFF and outranks everything below.
- ON: manual_driving_signal → NOT_START.
- NOT_START:
  - throttle & ~brake & clutch → START.
  - throttle & ~brake & ~clutch → OFF (stall).
- START:
  - brake → NOT_START.
  - throttle & ~clutch → MOVING.
- MOVING, in this order:
  - reverse change (reverse_signal ≠ rev_q) & ~clutch → OFF, with a reverse_fault pulse.
  - brake → NOT_START.
  - clutch | ~throttle → START.
  - otherwise stay.
- rev_q is reverse_signal registered every cycle. It resets to 0.

**Outputs.** All outputs are registered and computed from the next state, so they change on the same edge as state_o.
- Motion bits:
  - move_forward = MOVING & ~reverse_signal.
  - move_backward = MOVING & reverse_signal.
  - turn_left = MOVING & turn_left_signal; turn_right likewise.
  - All are 0 in every other state.
- Turn LEDs:
  - NOT_START: both LEDs steadily 1.
  - MOVING: each LED flashes while its turn signal is 1, and is 0 when its signal is 0.
  - All other states: 0.
- Flasher:
  - The flash counter runs only while in MOVING with either turn signal at 1.
  - Otherwise it is held at 0 with phase = on, so the LED lights on the first cycle the signal is seen.
  - The phase toggles every FLASH_CYC cycles.
- reverse_led = reverse_signal in START and MOVING, else 0.

**Odometer**
- tick_cnt increments each cycle in MOVING. At ODO_TICK_CYC-1 it wraps to 0 and odometer increments.
- odometer wraps modulo 2^ODO_W.
- In ON, NOT_START and START, tick_cnt and odometer hold their values.
- In OFF, both clear to 0.

## Timing

**Reset value of every output:** 0. This covers state_o = OFF, all LEDs, motion bits, odometer and reverse_fault; all internal counters and rev_q also reset to 0. Reset asserted mid-operation returns to this state immediately (asynchronous); operation resumes on the first clock after release.

**Power-up latency:** power_on_signal rising before edge k gives state_o = ON after edge k+HOLD_CYC-1. A 0 for a single cycle restarts the count.

**Other transitions:** one-edge latency from the input condition to state_o.

**reverse_fault:** high for exactly one cycle, coincident with state_o becoming OFF.

**Simultaneous events in MOVING:**
- power_off plus a reverse change: OFF, no fault pulse.
- Reverse change with clutch = 1 and brake = 1: NOT_START, no fault.

## Structure

**Package `drive_pkg`:**
- State codes OFF/ON/NOT_START/START/MOVING and the state width (3).

**Sub-module:**
- `turn_flasher`, instanced once per LED. Parameter FLASH_CYC; ports sys_clk, rst, en, led.
- Hold counter and tick counter stay inline.

## Test plan

Bench parameters: HOLD_CYC = 8, FLASH_CYC = 4, ODO_TICK_CYC = 5, ODO_W = 4.

1. Power-up: power_on held 8 cycles → ON on edge 8; held 7 cycles, dropped for 1, then held → no ON until a further 8 full cycles.
2. Drive sequence: manual_driving → NOT_START (both turn LEDs 1). Throttle+clutch → START. Release clutch → MOVING with move_forward = 1. After 12 cycles in MOVING → odometer = 2.
3. Flash: in MOVING set turn_left → left_turn_led 1 for 4 cycles, 0 for 4, 1 again; right_turn_led stays 0; turn_left = 1.
4. Reverse fault:
   - In MOVING with clutch = 0, toggle reverse → OFF plus a one-cycle reverse_fault, with odometer cleared.
   - Same toggle with clutch = 1 → START, move_backward = 0, reverse_led = 1, no fault.
5. Stall and priority:
   - NOT_START with throttle, no clutch → OFF.
   - MOVING with brake and a reverse change, no clutch → OFF.
   - MOVING with power_off and brake → OFF, no fault.
6. Reset mid-MOVING (odometer = 3) → all outputs 0 immediately; after release, state stays OFF.
